ram64_reader: RTL and testbench

- Read-side initiator for a ram64 instance. It drives the RAM address with load held low and samples the RAM output.
- It streams a contiguous block of words onto a valid/ready output channel.
- Software or a sequencer supplies a base address and a length, pulses start, and waits for done.
- Targets a ram64 whose out is combinational in address when load=0. The RAM write port is left to other initiators.

---
 rtl/ram64_reader.sv | 92 +++++++++
 tb/tb_ram64_reader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ram64_reader.sv
// rtl/ram64_reader.sv - streams a contiguous block of ram64 words onto a valid/ready channel
// Reads only: address tracks the fetch pointer, load is tied low, out is captured into a one-word stage.
module ram64_reader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << ADDR_W);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_ptr_q, fetch_ptr_d;
  logic [LEN_W-1:0]    to_fetch_q, to_fetch_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                fetch_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      fetch_ptr_q <= '0;
      to_fetch_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_ptr_q <= fetch_ptr_d;
      to_fetch_q  <= to_fetch_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fetch_ptr_d = fetch_ptr_q;
    to_fetch_d  = to_fetch_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    fetch_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          fetch_ptr_d = base;
          to_fetch_d  = (len > MAX_LEN) ? MAX_LEN : len;
          state_d     = (len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // Refill the output stage whenever it is empty or being drained this edge.
        fetch_en = (to_fetch_q != '0) && (!out_valid_q || out_ready);
        if (to_fetch_q == '0 && (!out_valid_q || out_ready)) begin
          out_valid_d = 1'b0;
          state_d     = S_DONE;
        end else if (fetch_en) begin
          out_data_d  = mem_out;
          out_valid_d = 1'b1;
          fetch_ptr_d = fetch_ptr_q + ADDR_W'(1);
          to_fetch_d  = to_fetch_q - LEN_W'(1);
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q == S_RUN) || (state_q == S_DONE);
  assign done        = (state_q == S_DONE);
  assign mem_address = fetch_ptr_q;
  assign mem_load    = 1'b0;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_ram64_reader.sv
// tb/tb_ram64_reader.sv - directed vector bench for ram64_reader with a behavioural ram64
// Each table row is one request; the reset-abort case is a hand-written sequence.
module tb_ram64_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  base;
  logic [6:0]  len;
  logic        busy;
  logic        done;
  logic [5:0]  mem_address;
  logic        mem_load;
  logic [15:0] mem_out;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  logic [15:0] mem [64];

  int tests;
  int fails;

  typedef struct {
    logic [5:0]  base;
    logic [6:0]  len;
    int          rmode;
    bit          pre_wrap;
    int          restart_t;
    int          exp_n;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
    int          exp_done_t;
  } vec_t;

  vec_t vecs [8];

  ram64_reader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base        (base),
    .len         (len),
    .busy        (busy),
    .done        (done),
    .mem_address (mem_address),
    .mem_load    (mem_load),
    .mem_out     (mem_out),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  assign mem_out = mem[mem_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic ready_at(input int rmode, input int t);
    logic [6:0] pat;
    pat = 7'b1101001;
    if (rmode == 0) return 1'b1;
    return pat[(t - 1) % 7];
  endfunction

  task automatic run_xfer(input vec_t v);
    int          got_n;
    int          done_n;
    int          done_t;
    logic        prev_valid;
    logic        prev_ready;
    logic [15:0] prev_data;
    logic [15:0] first_w;
    logic [15:0] last_w;
    if (v.pre_wrap) begin
      mem[62] = 16'hAAAA; mem[63] = 16'hBBBB; mem[0] = 16'hCCCC;
    end else begin
      mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    end
    got_n = 0; done_n = 0; done_t = -1;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_data = '0;
    first_w = '0; last_w = '0;
    @(negedge clk);
    start = 1'b1; base = v.base; len = v.len; out_ready = 1'b1;
    for (int t = 1; t <= 200; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (t == v.restart_t) begin
        start = 1'b1; base = 6'd10; len = 7'd2;
      end
      out_ready = ready_at(v.rmode, t);
      check("mem_load", {31'd0, mem_load}, 32'd0);
      if (prev_valid && !prev_ready) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data", {16'd0, out_data}, {16'd0, prev_data});
      end
      if (out_valid && out_ready) begin
        check("word", {16'd0, out_data}, {16'd0, mem[6'(v.base + 6'(got_n))]});
        if (got_n == 0) first_w = out_data;
        last_w = out_data;
        got_n++;
      end
      if (done) begin
        done_n++;
        if (done_t < 0) done_t = t;
      end
      prev_valid = out_valid; prev_ready = out_ready; prev_data = out_data;
      if (done_t >= 0 && t == done_t + 1) begin
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);
        break;
      end
    end
    start = 1'b0;
    check("word_count", got_n, v.exp_n);
    check("done_pulses", done_n, 32'd1);
    if (v.exp_done_t > 0) check("done_time", done_t, v.exp_done_t);
    if (v.exp_n > 0) begin
      check("first_word", {16'd0, first_w}, {16'd0, v.exp_first});
      check("last_word", {16'd0, last_w}, {16'd0, v.exp_last});
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    for (int i = 0; i < 64; i++) mem[i] = 16'h5000 + 16'(i);
    vecs[0] = '{6'd0,  7'd4,   0, 1'b0, 0, 4,  16'h1111, 16'h4444, 6};
    vecs[1] = '{6'd62, 7'd3,   0, 1'b1, 0, 3,  16'hAAAA, 16'hCCCC, 5};
    vecs[2] = '{6'd0,  7'd4,   1, 1'b0, 0, 4,  16'h1111, 16'h4444, 9};
    vecs[3] = '{6'd5,  7'd0,   0, 1'b0, 0, 0,  16'h0000, 16'h0000, 1};
    vecs[4] = '{6'd0,  7'd100, 0, 1'b0, 0, 64, 16'h1111, 16'hBBBB, 66};
    vecs[5] = '{6'd60, 7'd8,   0, 1'b0, 0, 8,  16'h503C, 16'h4444, 10};
    vecs[6] = '{6'd1,  7'd64,  0, 1'b0, 0, 64, 16'h2222, 16'h1111, 66};
    vecs[7] = '{6'd0,  7'd4,   0, 1'b0, 2, 4,  16'h1111, 16'h4444, 6};

    rst_n = 1'b0; start = 1'b0; base = '0; len = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {16'd0, out_data}, 32'd0);
    check("rst_addr", {26'd0, mem_address}, 32'd0);
    check("rst_load", {31'd0, mem_load}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_xfer(vecs[i]);

    // Abort after two of four words, then confirm the block restarts cleanly.
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    @(negedge clk);
    start = 1'b1; base = 6'd0; len = 7'd4; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_w0", {16'd0, out_data}, 32'h1111);
    @(negedge clk);
    check("abort_w1", {16'd0, out_data}, 32'h2222);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_no_done", {31'd0, done}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("after_rst_done", {31'd0, done}, 32'd0);
    run_xfer('{6'd2, 7'd2, 0, 1'b0, 0, 2, 16'h3333, 16'h4444, 4});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
